// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its consumers.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // SLL r0,r0,0: the canonical bubble instruction
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int OP_LSB  = 26;
  localparam int FUNCT_W = 6;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with flush > stall > load > bubble priority and NOP injection.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        fetched_o,
  output logic        bubble_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    fetched_o = 1'b0;
    bubble_o  = 1'b0;
    if (flush_i) begin
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      bubble_o = 1'b1;
    end else if (!stall_i) begin
      if (load_i) begin
        instr_d   = instr_i;
        pc4_d     = pc_plus4_i;
        valid_d   = 1'b1;
        fetched_o = 1'b1;
      end else begin
        instr_d  = NOP_INSTR;
        valid_d  = 1'b0;
        bubble_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS IF stage: PC, single-outstanding imem handshake, one-word stall buffer, redirect.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [5:0]  op_d,
  output logic [5:0]  funct_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        load, from_buf;
  logic        fetched_s, bubble_s;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    load         = 1'b0;
    from_buf     = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          // A same-cycle branch is newer than any pending redirect
          if (branch_taken) begin
            pc_d         = branch_target;
            redir_pend_d = 1'b0;
          end else if (redir_pend_q) begin
            pc_d         = redir_tgt_q;
            redir_pend_d = 1'b0;
          end else begin
            pc_d = pc_plus4;
            if (stall_f) begin
              buf_instr_d = imem_rdata;
              buf_pc4_d   = pc_plus4;
              state_d     = S_HOLD;
            end else begin
              load = 1'b1;
            end
          end
        end else if (branch_taken) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = branch_target;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = S_REQ;
        end else if (!stall_f) begin
          load     = 1'b1;
          from_buf = 1'b1;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
      buf_instr_q  <= NOP_WORD;
      buf_pc4_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc4_q    <= buf_pc4_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;

  if_id_reg #(.NOP_INSTR(NOP_WORD)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_d | branch_taken),
    .stall_i    (stall_f),
    .load_i     (load),
    .instr_i    (from_buf ? buf_instr_q : imem_rdata),
    .pc_plus4_i (from_buf ? buf_pc4_q : pc_plus4),
    .instr_o    (instr_d),
    .pc_plus4_o (pc_plus4_d),
    .valid_o    (valid_d),
    .fetched_o  (fetched_s),
    .bubble_o   (bubble_s)
  );

  assign op_d    = instr_d[31:OP_LSB];
  assign funct_d = instr_d[FUNCT_W-1:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (fetched_s) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (bubble_s)  perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic perf_unused;
  assign perf_unused  = fetched_s ^ bubble_s;
  assign perf_fetched = 32'h0;
  assign perf_bubbles = 32'h0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the decode-stage control unit.
- Owns the PC, runs a single-outstanding request/acknowledge handshake to instruction memory, and buffers one returned word when decode is stalled.
- Drives the IF/ID pipeline register. Decode reads op_d and funct_d from that register.
- Handles branch redirect, including a redirect that arrives while a fetch is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID on a bubble or flush (decodes as SLL r0,r0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_f  in  1  hazard unit: hold IF/ID contents, accept no new instruction into decode.
- flush_d  in  1  squash IF/ID: next cycle valid_d=0, instr_d=NOP_WORD.
- branch_taken  in  1  redirect request from decode, single-cycle pulse.
- branch_target  in  32  redirect PC, sampled when branch_taken=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  response strobe; imem_rdata is valid in this cycle.
- imem_rdata  in  32  instruction word.
- instr_d  out  32  IF/ID instruction.
- op_d  out  6  instr_d[31:26].
- funct_d  out  6  instr_d[5:0].
- pc_plus4_d  out  32  IF/ID PC+4 of instr_d.
- valid_d  out  1  instr_d is a real instruction.

Behaviour:
- Reset values (asynchronous): pc=RESET_PC, state=S_BOOT, imem_req=0, instr_d=NOP_WORD, pc_plus4_d=0, valid_d=0, buffer empty, redir_pend=0.
- Memory handshake:
  - imem_req and imem_addr stay stable from assertion until the imem_ack cycle.
  - imem_ack is never earlier than one cycle after imem_req rises.
  - At most one request is outstanding.
  - imem_addr = pc; bits [1:0] are always 0.
- State S_BOOT: req=0 for exactly one cycle after rst_n deasserts, then S_REQ.
- State S_REQ: req=1.
  - Ack with redir_pend=1: discard rdata, pc<=redir_tgt, clear redir_pend, stay S_REQ. The new address appears the next cycle.
  - Ack with branch_taken=1 in the same cycle: discard rdata, pc<=branch_target, stay S_REQ.
  - Ack, no redirect, stall_f=0: IF/ID<={rdata, pc+4, valid=1}, pc<=pc+4, stay S_REQ. This gives back-to-back fetch.
  - Ack, no redirect, stall_f=1: buf<={rdata, pc+4}, pc<=pc+4, go S_HOLD.
  - No ack and branch_taken=1: redir_pend<=1, redir_tgt<=branch_target. Address stays unchanged.
  - A second branch_taken while redir_pend=1 overwrites redir_tgt.
- State S_HOLD: req=0.
  - branch_taken=1: drop buf, pc<=branch_target, go S_REQ.
  - stall_f=0 and flush_d=0: IF/ID<=buf with valid=1, go S_REQ.
  - stall_f=0 and flush_d=1: drop buf, go S_REQ.
- IF/ID update priority, highest first:
  1. flush_d or branch_taken: valid_d=0, instr_d=NOP_WORD.
  2. stall_f: hold.
  3. Fresh word (ack or buffer release): load it.
  4. Otherwise insert a bubble: valid_d=0, instr_d=NOP_WORD.
- Latency:
  - Address to instr_d is memory latency + 1 cycle.
  - A taken branch costs at least 2 bubbles.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- A reset asserted mid-request abandons the request. The memory side must tolerate req falling before ack.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Two 32-bit wrapping counters, reset to 0.
  - perf_fetched increments on each instruction loaded into IF/ID with valid=1.
  - perf_bubbles increments on each cycle valid_d is written 0.
  - Both are exposed as output ports perf_fetched[31:0] and perf_bubbles[31:0].
- Not defined: both ports exist and are tied to 32'h0, and no counter flops are built.

Decomposition:
- Package fetch_pkg holds:
  - state enum S_BOOT/S_REQ/S_HOLD (2-bit);
  - NOP_WORD;
  - OP_LSB=26 and FUNCT_W=6 slice constants, shared with the control unit.
- One natural sub-module: if_id_reg. It holds the IF/ID register with flush/stall/load priority and NOP injection, and is reused for the flush semantics of later pipeline registers.

Test Plan:
- Reset, then memory with 1-cycle ack: imem_addr sequence 0,4,8; instr_d equals the rdata values one cycle after each ack; pc_plus4_d = 4,8,12; valid_d=1 continuously after the first word.
- stall_f held 3 cycles while ack returns word at 0x10: state S_HOLD, req=0; word appears in instr_d the cycle after stall_f drops; next imem_addr=0x14.
- 3-cycle memory, branch_taken to 0x200 one cycle after req to 0x40: addr stays 0x40 until ack; that word is discarded (valid_d=0); next addr=0x200.
- branch_taken coincident with ack at 0x80, target 0x100: the 0x80 data never reaches decode; next addr=0x100; valid_d=0 that cycle.
- flush_d while in S_HOLD: buffer dropped, valid_d=0, next fetch at buffered pc+4; with FETCH_PERF_CNT_EN, perf_bubbles increments by the exact number of bubble cycles.
- PC at 32'hFFFF_FFFC, ack: next imem_addr=0; rst_n pulsed mid-request: req=0 asynchronously, restart at RESET_PC after one S_BOOT cycle.
